// File: rtl/led_pkg.sv
// led_pkg: shared state encoding, default geometry and counter-width helper for the LED chain controller
package led_pkg;
    typedef enum logic [1:0] {ACCEPT, SHIFT, LATCH} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_WORDS = 2;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_serializer.sv
// led_serializer: hold register and bit counter presenting one word MSB-first on sh_data
module led_serializer
    import led_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] in_data,
    output logic             sh_data,
    output logic             last
);
    localparam int BW = cnt_w(WIDTH);
    logic [WIDTH-1:0] hold;
    logic [BW-1:0]    bit_cnt;
    assign last = bit_cnt == '0;
    // load presents the MSB immediately; each shift cycle steps to the next lower bit
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold    <= '0;
            bit_cnt <= '0;
            sh_data <= 1'b0;
        end else if (load) begin
            hold    <= in_data;
            bit_cnt <= BW'(WIDTH - 1);
            sh_data <= in_data[WIDTH-1];
        end else if (shift && !last) begin
            bit_cnt <= bit_cnt - 1'b1;
            sh_data <= hold[bit_cnt-1'b1];
        end
    end
endmodule

// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: frame sequencer for the LED shift-register chain; LED_SHIFT_BLANK_EN adds blank_n
module led_shift_ctrl
    import led_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sh_data,
    output logic             sh_en_n,
    output logic             latch,
    output logic             busy,
`ifdef LED_SHIFT_BLANK_EN
    output logic             frame_done,
    output logic             blank_n
`else
    output logic             frame_done
`endif
);
    localparam int WC = cnt_w(WORDS);
    state_t        state, nx;
    logic [WC-1:0] word_cnt;
    logic          load, shift, last, word_last;
    assign in_ready  = state == ACCEPT;
    assign busy      = (state != ACCEPT) || (word_cnt != '0);
    assign load      = in_valid && in_ready && !clear;
    assign shift     = (state == SHIFT) && !clear;
    assign word_last = word_cnt == WC'(WORDS - 1);
    led_serializer #(.WIDTH(WIDTH)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .in_data (in_data),
        .sh_data (sh_data),
        .last    (last)
    );
    // next state: clear aborts to ACCEPT, last bit of the final word goes to LATCH
    always_comb begin
        nx = state;
        nx = clear ? ACCEPT :
             load ? SHIFT :
             (state == SHIFT && last) ? (word_last ? LATCH : ACCEPT) :
             (state == LATCH) ? ACCEPT : state;
    end
    // state register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ACCEPT;
            sh_en_n    <= 1'b1;
            latch      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nx;
            sh_en_n    <= nx != SHIFT;
            latch      <= nx == LATCH;
            frame_done <= nx == LATCH;
        end
    end
    // word position within the frame; cleared on abort and after the latch strobe
    always_ff @(posedge clk) begin
        if (!reset || clear || state == LATCH) word_cnt <= '0;
        else if (state == SHIFT && last && !word_last) word_cnt <= word_cnt + 1'b1;
    end
`ifdef LED_SHIFT_BLANK_EN
    // blank the LEDs from the first shift of a frame until after its latch or an abort
    always_ff @(posedge clk) begin
        if (!reset || clear || state == LATCH) blank_n <= 1'b1;
        else if (nx == SHIFT) blank_n <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_led_shift_ctrl.sv
// tb_led_shift_ctrl: directed self-checking bench with a 16-bit chain and latch model
module tb_led_shift_ctrl;
    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic [7:0] in_data;
    logic       in_ready, sh_data, sh_en_n, latch, busy, frame_done;
`ifdef LED_SHIFT_BLANK_EN
    logic       blank_n;
`endif
    int         pass = 0, total = 0;
    int         cyc = 0, nlatch = 0, lat_cyc = 0, nacc = 0;
    int         acc, nl0, na0;
    logic [15:0] chain = '0, latched = '0, saved, exp;

    always #5 clk = ~clk;

    led_shift_ctrl #(.WIDTH(8), .WORDS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sh_data    (sh_data),
        .sh_en_n    (sh_en_n),
        .latch      (latch),
        .busy       (busy),
`ifdef LED_SHIFT_BLANK_EN
        .frame_done (frame_done),
        .blank_n    (blank_n)
`else
        .frame_done (frame_done)
`endif
    );

    // external chain: shifts on enabled edges, latch copies it to the LED outputs
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sh_en_n) chain <= {chain[14:0], sh_data};
        if (latch) begin
            nlatch  <= nlatch + 1;
            lat_cyc <= cyc + 1;
            latched <= chain;
        end
        if (in_valid && in_ready && !clear && reset) nacc <= nacc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic send(input logic [7:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick;
            n++;
        end
        chk("send_ready", 32'(n < 100), 1);
        tick;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((busy || !in_ready) && n < 100) begin
            tick;
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 1);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        tick; tick; tick;
        chk("rst_sh_data", sh_data, 0);
        chk("rst_frame_done", frame_done, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("idle_ready", in_ready, 1);
            chk("idle_en_n", sh_en_n, 1);
            chk("idle_latch", latch, 0);
            chk("idle_busy", busy, 0);
`ifdef LED_SHIFT_BLANK_EN
            chk("idle_blank", blank_n, 1);
`endif
            tick;
        end

        // back-to-back frame 0xA5, 0x3C
        nl0 = nlatch;
        exp = 16'hA53C;
        in_data = 8'hA5; in_valid = 1'b1;
        tick;
        acc = cyc;
        in_data = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            chk("w0_en_n", sh_en_n, 0);
            chk("w0_bit", sh_data, exp[15-i]);
            chk("w0_ready", in_ready, 0);
`ifdef LED_SHIFT_BLANK_EN
            chk("w0_blank", blank_n, 0);
`endif
            tick;
        end
        chk("gap_en_n", sh_en_n, 1);
        chk("gap_ready", in_ready, 1);
        chk("gap_busy", busy, 1);
`ifdef LED_SHIFT_BLANK_EN
        chk("gap_blank", blank_n, 0);
`endif
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("w1_en_n", sh_en_n, 0);
            chk("w1_bit", sh_data, exp[7-i]);
            tick;
        end
        chk("lat_latch", latch, 1);
        chk("lat_done", frame_done, 1);
        chk("lat_busy", busy, 1);
        chk("lat_ready", in_ready, 0);
        chk("lat_en_n", sh_en_n, 1);
        tick;
        chk("post_latch", latch, 0);
        chk("post_done", frame_done, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", in_ready, 1);
`ifdef LED_SHIFT_BLANK_EN
        chk("post_blank", blank_n, 1);
`endif
        chk("f1_value", latched, 16'hA53C);
        chk("f1_pulses", nlatch - nl0, 1);
        chk("f1_latch_cycle", lat_cyc - acc + 1, 19);

        // valid held high through shifting: accepted exactly once
        nl0 = nlatch; na0 = nacc;
        in_data = 8'h81; in_valid = 1'b1;
        tick;
        in_data = 8'h42;
        for (int i = 0; i < 8; i++) begin
            chk("hold_ready", in_ready, 0);
            tick;
        end
        chk("hold_ready_up", in_ready, 1);
        tick;
        in_valid = 1'b0;
        wait_idle;
        chk("hold_accepts", nacc - na0, 2);
        chk("hold_value", latched, 16'h8142);

        // long gap between words
        nl0 = nlatch;
        send(8'hFF);
        for (int i = 0; i < 8; i++) tick;
        chk("gap20_ready", in_ready, 1);
        saved = chain;
        for (int i = 0; i < 20; i++) begin
            chk("gap20_en_n", sh_en_n, 1);
            tick;
        end
        chk("gap20_chain", chain, saved);
        chk("gap20_low", chain[7:0], 8'hFF);
        send(8'h00);
        wait_idle;
        chk("gap20_value", latched, 16'hFF00);
        chk("gap20_pulses", nlatch - nl0, 1);

        // abort in the 4th shift cycle of word 1
        nl0 = nlatch;
        send(8'h11);
        send(8'h22);
        tick; tick; tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr_en_n", sh_en_n, 1);
        chk("clr_busy", busy, 0);
        chk("clr_ready", in_ready, 1);
`ifdef LED_SHIFT_BLANK_EN
        chk("clr_blank", blank_n, 1);
`endif
        tick; tick; tick;
        chk("clr_no_latch", nlatch - nl0, 0);
        send(8'h5A);
        send(8'h6B);
        wait_idle;
        chk("clr_value", latched, 16'h5A6B);
        chk("clr_pulses", nlatch - nl0, 1);

        // reset mid-frame
        send(8'h77);
        tick; tick; tick;
        reset = 1'b0;
        tick;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", sh_data, 0);
        chk("mid_rst_en_n", sh_en_n, 1);
        chk("mid_rst_latch", latch, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frame_done, 0);
`ifdef LED_SHIFT_BLANK_EN
        chk("mid_rst_blank", blank_n, 1);
`endif
        reset = 1'b1;
        tick;
        chk("after_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
